gray_count_decoder: RTL and testbench

GRAY_COUNT_DECODER -- requirements
Module: gray_count_decoder

---
 rtl/gray_pkg.sv | 13 +
 rtl/gray2bin.sv | 21 ++
 rtl/gray_count_decoder.sv | 116 +++++++++++
 tb/tb_gray_count_decoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and defaults for the Gray count decoder.
package gray_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_CNT = 3;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray2bin #(
    parameter int WIDTH = gray_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Running XOR from the MSB down produces the binary value.
    always_comb begin
        logic acc;
        acc = 1'b0;
        bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/gray_count_decoder.sv
// Observes a Gray-coded counter, decodes it to binary and classifies each
// sample-to-sample step as hold, +1, -1 or illegal. A short run of forward
// steps declares the counter locked; any backward or illegal step drops it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ACQUIRE | no history; next enabled sample only seeds the previous value
// TRACK   | history valid; counting consecutive forward steps toward lock
// LOCKED  | sequence accepted as a forward count; holds until a bad step
module gray_count_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cen,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_fwd,
    output logic             step_bwd,
    output logic             step_err,
    output logic             locked,
    output logic [7:0]       err_count
);

    localparam int RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [WIDTH-1:0] b_prev;
    logic [WIDTH-1:0] b_new;
    logic [WIDTH-1:0] delta;
    logic             is_fwd;
    logic             is_bwd;
    logic             is_err;
    logic [RUN_W-1:0] run_inc;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (gray_in),
        .bin  (b_new)
    );

    // Modular difference between the new and previous sample; a wrap from
    // all-ones to zero falls out naturally as +1.
    always_comb begin
        delta   = b_new - b_prev;
        is_fwd  = (delta == WIDTH'(1));
        is_bwd  = (delta == {WIDTH{1'b1}});
        is_err  = (delta != '0) && !is_fwd && !is_bwd;
        run_inc = run + 1'b1;
    end

    // Sample register, step pulses, lock FSM and saturating error counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ACQUIRE;
            run       <= '0;
            b_prev    <= '0;
            step_fwd  <= 1'b0;
            step_bwd  <= 1'b0;
            step_err  <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            step_fwd <= 1'b0;
            step_bwd <= 1'b0;
            step_err <= 1'b0;
            if (cen) begin
                b_prev <= b_new;
                if (state != ACQUIRE) begin
                    step_fwd <= is_fwd;
                    step_bwd <= is_bwd;
                    step_err <= is_err;
                    if (is_err && (err_count != 8'hFF))
                        err_count <= err_count + 8'd1;
                end
                case (state)
                    ACQUIRE: begin
                        run    <= '0;
                        state  <= TRACK;
                        locked <= 1'b0;
                    end
                    TRACK: begin
                        if (is_fwd) begin
                            run <= run_inc;
                            if (run_inc == LOCK_RUN) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (is_bwd || is_err) begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (is_bwd || is_err) begin
                            run    <= '0;
                            state  <= TRACK;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        run    <= '0;
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bin_out = b_prev;

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed bench for gray_count_decoder with a reference model feeding a
// scoreboard of expected outputs.
module tb_gray_count_decoder;

    logic       clk;
    logic       reset_n;
    logic       cen;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic       step_fwd;
    logic       step_bwd;
    logic       step_err;
    logic       locked;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int bin;
        int fwd;
        int bwd;
        int err;
        int lk;
        int ec;
    } exp_t;

    exp_t sb[$];

    // reference model state: 0=acquire 1=track 2=locked
    int m_state = 0;
    int m_run   = 0;
    int m_prev  = 0;
    int m_ec    = 0;

    int fwd_seen = 0;
    int err_seen = 0;

    gray_count_decoder #(.WIDTH(4), .LOCK_CNT(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cen       (cen),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .step_fwd  (step_fwd),
        .step_bwd  (step_bwd),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle: bval is a binary count value sent as its Gray code.
    task automatic drive(input logic rn, input logic c, input int bval, input string tag);
        exp_t e;
        int   d;
        logic [3:0] bv;
        bv = 4'(bval);
        reset_n = rn;
        cen     = c;
        gray_in = bv ^ (bv >> 1);
        e.fwd = 0; e.bwd = 0; e.err = 0;
        if (!rn) begin
            m_state = 0; m_run = 0; m_prev = 0; m_ec = 0;
        end else if (c) begin
            if (m_state == 0) begin
                m_state = 1;
                m_run   = 0;
            end else begin
                d = (int'(bv) - m_prev + 16) % 16;
                e.fwd = (d == 1)  ? 1 : 0;
                e.bwd = (d == 15) ? 1 : 0;
                e.err = (d != 0 && d != 1 && d != 15) ? 1 : 0;
                if (e.err == 1 && m_ec < 255) m_ec++;
                if (m_state == 1) begin
                    if (e.fwd == 1) begin
                        m_run++;
                        if (m_run == 3) m_state = 2;
                    end else if (e.bwd == 1 || e.err == 1) begin
                        m_run = 0;
                    end
                end else if (e.bwd == 1 || e.err == 1) begin
                    m_state = 1;
                    m_run   = 0;
                end
            end
            m_prev = int'(bv);
        end
        e.bin = m_prev;
        e.lk  = (m_state == 2) ? 1 : 0;
        e.ec  = m_ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (step_fwd === 1'b1) fwd_seen++;
        if (step_err === 1'b1) err_seen++;
        check({tag, ".bin"},    int'(bin_out),   e.bin);
        check({tag, ".fwd"},    int'(step_fwd),  e.fwd);
        check({tag, ".bwd"},    int'(step_bwd),  e.bwd);
        check({tag, ".err"},    int'(step_err),  e.err);
        check({tag, ".locked"}, int'(locked),    e.lk);
        check({tag, ".errcnt"}, int'(err_count), e.ec);
    endtask

    initial begin
        reset_n = 1'b0;
        cen     = 1'b0;
        gray_in = '0;

        drive(1'b0, 1'b0, 0, "reset0");
        drive(1'b0, 1'b1, 5, "reset1");

        // first samples: acquire, then lock on the fourth
        drive(1'b1, 1'b1, 0, "seq0");
        check("seq0_nopulse", int'(step_fwd | step_bwd | step_err), 0);
        fwd_seen = 0;
        err_seen = 0;
        for (int i = 1; i <= 3; i++) drive(1'b1, 1'b1, i, "seq");
        check("lock_at_4th", int'(locked), 1);

        // rest of a full forward cycle including the 15 -> 0 wrap
        for (int i = 4; i <= 16; i++) drive(1'b1, 1'b1, i % 16, "cycle");
        check("cycle_fwd_count", fwd_seen, 16);
        check("cycle_no_err", err_seen, 0);
        check("cycle_errcnt", int'(err_count), 0);

        // illegal step 3 -> 5 while locked, then relock
        for (int i = 1; i <= 3; i++) drive(1'b1, 1'b1, i, "pre_err");
        drive(1'b1, 1'b1, 5, "inj_err");
        check("inj_err_pulse", int'(step_err), 1);
        check("inj_err_unlock", int'(locked), 0);
        drive(1'b1, 1'b1, 6, "relock");
        drive(1'b1, 1'b1, 7, "relock");
        check("relock_not_yet", int'(locked), 0);
        drive(1'b1, 1'b1, 8, "relock");
        check("relock_done", int'(locked), 1);

        // backward steps 2 -> 1 and 0 -> 15
        drive(1'b1, 1'b1, 2, "to2");
        drive(1'b1, 1'b1, 1, "bwd_2_1");
        drive(1'b1, 1'b1, 0, "bwd_1_0");
        drive(1'b1, 1'b1, 15, "bwd_wrap");
        check("bwd_wrap_pulse", int'(step_bwd), 1);

        // lock, then freeze with cen=0 and toggling input, then hold
        drive(1'b1, 1'b1, 0, "lk");
        drive(1'b1, 1'b1, 1, "lk");
        drive(1'b1, 1'b1, 2, "lk");
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, $urandom_range(0, 15), "frozen");
        drive(1'b1, 1'b1, 2, "hold");
        drive(1'b1, 1'b1, 2, "hold");
        check("hold_locked", int'(locked), 1);

        // saturate the error counter
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, (i % 2 == 0) ? 10 : 2, "sat");
        check("sat_255", int'(err_count), 255);

        // mid-stream reset with cen high, then fresh acquire
        drive(1'b0, 1'b1, 9, "mid_reset");
        drive(1'b1, 1'b1, 7, "post_reset");
        check("post_reset_nopulse", int'(step_fwd | step_bwd | step_err), 0);
        drive(1'b1, 1'b1, 8, "post_reset_fwd");

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
